// File: rtl/i2s_pkg.sv
// Shared I2S definitions: sample-size codes, channel encoding and receiver FSM states.
// Used by both the I2S transmitter and receiver so framing stays consistent.
package i2s_pkg;

  localparam logic [3:0] S_8BIT  = 4'd0;
  localparam logic [3:0] S_12BIT = 4'd1;
  localparam logic [3:0] S_16BIT = 4'd3;
  localparam logic [3:0] S_24BIT = 4'd4;
  localparam logic [3:0] S_32BIT = 4'd5;

  // WS level for each channel
  localparam logic LEFT  = 1'b0;
  localparam logic RIGHT = 1'b1;

  localparam logic [1:0] ST_HUNT  = 2'd0;
  localparam logic [1:0] ST_LEFT  = 2'd1;
  localparam logic [1:0] ST_RIGHT = 2'd2;

  // Unlisted codes fall back to full 32-bit words.
  function automatic logic [5:0] size_decode(input logic [3:0] code);
    logic [5:0] bits;
    case (code)
      S_8BIT:  bits = 6'd8;
      S_12BIT: bits = 6'd12;
      S_16BIT: bits = 6'd16;
      S_24BIT: bits = 6'd24;
      S_32BIT: bits = 6'd32;
      default: bits = 6'd32;
    endcase
    return bits;
  endfunction

endpackage

// File: rtl/i2s_rx_sync.sv
// Brings SCK, WS and SD into the clk domain and produces a one-cycle strobe
// per SCK falling edge, with WS/SD delayed to line up with that strobe.
module i2s_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic sck_in,
  input  logic ws_in,
  input  logic sd_in,
  output logic ws_s,
  output logic sd_s,
  output logic bit_strobe
);

  logic [1:0] sck_sync_q;
  logic [1:0] ws_sync_q;
  logic [1:0] sd_sync_q;
  logic       sck_prev_q;
  logic       strobe_q;
  logic       ws_q;
  logic       sd_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync_q <= 2'b00;
      ws_sync_q  <= 2'b00;
      sd_sync_q  <= 2'b00;
      sck_prev_q <= 1'b0;
      strobe_q   <= 1'b0;
      ws_q       <= 1'b0;
      sd_q       <= 1'b0;
    end else begin
      sck_sync_q <= {sck_sync_q[0], sck_in};
      ws_sync_q  <= {ws_sync_q[0], ws_in};
      sd_sync_q  <= {sd_sync_q[0], sd_in};
      sck_prev_q <= sck_sync_q[1];
      // Registered edge detect; WS/SD get the same extra stage to stay aligned.
      strobe_q   <= sck_prev_q & ~sck_sync_q[1];
      ws_q       <= ws_sync_q[1];
      sd_q       <= sd_sync_q[1];
    end
  end

  assign ws_s       = ws_q;
  assign sd_s       = sd_q;
  assign bit_strobe = strobe_q;

endmodule

// File: rtl/i2s_receiver.sv
// I2S receiver: deserializes left/right words of a programmable size and
// presents each complete stereo frame through a one-entry valid/ready register.
module i2s_receiver
  import i2s_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sck_in,
  input  logic        ws_in,
  input  logic        sd_in,
  input  logic [3:0]  sample_size,
  output logic [31:0] sample_left,
  output logic [31:0] sample_right,
  output logic        valid,
  input  logic        ready,
  output logic        overrun,
  output logic        short_word
);

  logic ws_s;
  logic sd_s;
  logic bit_strobe;

  i2s_rx_sync u_sync (
    .clk        (clk),
    .rst        (rst),
    .sck_in     (sck_in),
    .ws_in      (ws_in),
    .sd_in      (sd_in),
    .ws_s       (ws_s),
    .sd_s       (sd_s),
    .bit_strobe (bit_strobe)
  );

  logic [1:0]  state_q, state_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [5:0]  size_q, size_d;
  logic        ws_prev_q, ws_prev_d;
  logic [31:0] word_q, word_d;
  logic [31:0] left_hold_q, left_hold_d;
  logic        frame_bad_q, frame_bad_d;
  logic [31:0] out_left_q, out_left_d;
  logic [31:0] out_right_q, out_right_d;
  logic        valid_q, valid_d;
  logic        overrun_q, overrun_d;
  logic        short_q, short_d;

  logic        chan_ws;
  logic        chan_short;
  logic        frame_done;

  assign chan_ws    = (state_q == ST_LEFT) ? LEFT : RIGHT;
  assign chan_short = (bit_cnt_q < size_q);

  // NOTE: every variable driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    size_d      = size_q;
    ws_prev_d   = ws_prev_q;
    word_d      = word_q;
    left_hold_d = left_hold_q;
    frame_bad_d = frame_bad_q;
    short_d     = 1'b0;
    frame_done  = 1'b0;

    if (bit_strobe) begin
      ws_prev_d = ws_s;
      case (state_q)
        ST_HUNT: begin
          if (ws_s == LEFT && ws_prev_q == RIGHT) begin
            state_d     = ST_LEFT;
            size_d      = size_decode(sample_size);
            frame_bad_d = 1'b0;
            word_d      = {31'd0, sd_s};
            bit_cnt_d   = 6'd1;
          end
        end
        ST_LEFT, ST_RIGHT: begin
          if (ws_s == chan_ws) begin
            if (chan_short) begin
              if (MSB_FIRST) word_d = {word_q[30:0], sd_s};
              else           word_d[bit_cnt_q[4:0]] = sd_s;
            end
            if (bit_cnt_q != 6'd32) bit_cnt_d = bit_cnt_q + 6'd1;
          end else begin
            // WS flip: this strobe's bit is already bit 0 of the next channel.
            short_d   = chan_short;
            word_d    = {31'd0, sd_s};
            bit_cnt_d = 6'd1;
            if (state_q == ST_LEFT) begin
              left_hold_d = word_q;
              frame_bad_d = chan_short;
              state_d     = ST_RIGHT;
            end else begin
              frame_done  = !frame_bad_q && !chan_short;
              size_d      = size_decode(sample_size);
              frame_bad_d = 1'b0;
              state_d     = ST_LEFT;
            end
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end

    out_left_d  = out_left_q;
    out_right_d = out_right_q;
    valid_d     = valid_q;
    overrun_d   = overrun_q;
    if (frame_done) begin
      out_left_d  = left_hold_q;
      out_right_d = word_q;
      valid_d     = 1'b1;
      if (valid_q && !ready) overrun_d = 1'b1;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_HUNT;
      bit_cnt_q   <= 6'd0;
      size_q      <= 6'd32;
      ws_prev_q   <= 1'b0;
      word_q      <= 32'd0;
      left_hold_q <= 32'd0;
      frame_bad_q <= 1'b0;
      out_left_q  <= 32'd0;
      out_right_q <= 32'd0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      short_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      size_q      <= size_d;
      ws_prev_q   <= ws_prev_d;
      word_q      <= word_d;
      left_hold_q <= left_hold_d;
      frame_bad_q <= frame_bad_d;
      out_left_q  <= out_left_d;
      out_right_q <= out_right_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      short_q     <= short_d;
    end
  end

  assign sample_left  = out_left_q;
  assign sample_right = out_right_q;
  assign valid        = valid_q;
  assign overrun      = overrun_q;
  assign short_word   = short_q;

endmodule

// File: doc/i2s_receiver.md
# i2s_receiver

Serial-to-parallel I2S receiver for the converter's loopback and capture path. Oversamples the external bit clock (SCK), word select (WS) and serial data (SD) in the `clk` domain. Deserializes left and right words of a programmable size and delivers each completed stereo frame over a valid/ready handshake. It is the receive counterpart of the team's I2S transmitter and decodes the same framing and bit order.

## Interface
- `MSB_FIRST`, default 0: 0 = first bit of a word is the LSB (team transmitter format); 1 = MSB first.
- `clk  in  1`: system clock. Must be at least 4× the SCK frequency.
- `rst  in  1`: reset, synchronous, active-high; clock clk.
- `sck_in  in  1`: external I2S bit clock, asynchronous.
- `ws_in  in  1`: word select, asynchronous. 0 = left, 1 = right.
- `sd_in  in  1`: serial data, asynchronous. Launched on the SCK rising edge.
- `sample_size  in  4`: word size code. 0 = 8, 1 = 12, 3 = 16, 4 = 24, 5 = 32. Any other code = 32.
- `sample_left  out  32`: left word, right-aligned, upper bits zero.
- `sample_right  out  32`: right word, right-aligned, upper bits zero.
- `valid  out  1`: frame available on `sample_left`/`sample_right`.
- `ready  in  1`: consumer accepts the frame when `valid && ready`.
- `overrun  out  1`: sticky. A completed frame replaced an unaccepted one.
- `short_word  out  1`: one-cycle pulse. A channel ended with fewer bits than the selected size.

## Operation
- **Input path:**
  - `sck_in`, `ws_in` and `sd_in` each pass through a 2-flop synchronizer of identical depth.
  - A third SCK flop gives the previous value. A falling edge is `sck_prev & ~sck_sync`.
  - All capture happens only on the cycle a synchronized SCK falling edge is detected (the "bit strobe").
- **Size latch:** `sample_size` is decoded to `size` (8–32) and latched at the start of each left channel. Mid-frame changes are ignored.
- **FSM states:** HUNT, LEFT, RIGHT.
  - HUNT: at each bit strobe, if WS = 0 and the previous strobe's WS = 1, go to LEFT, capture the current bit as bit 0, and set `bit_cnt = 1`. Otherwise stay in HUNT. Reset enters HUNT, so no partial frame is ever delivered.
  - LEFT: at a strobe with WS = 0, capture the bit if `bit_cnt < size` and increment `bit_cnt`, saturating at 32. Bits beyond `size` are discarded. A strobe with WS = 1 ends the channel: latch the left word, go to RIGHT, and capture that bit as right bit 0.
  - RIGHT: the same capture rule as LEFT. A strobe with WS = 0 ends the frame: latch the right word, present the frame, re-latch `size`, go to LEFT, and capture that bit as left bit 0.
- **Bit placement:**
  - With `MSB_FIRST` = 0, the word's bit index `bit_cnt` receives SD.
  - With `MSB_FIRST` = 1, the word shifts left with SD entering bit 0.
  - In both cases the result is right-aligned, with bits `[31:size]` zero.
- **Short word:**
  - A channel that ends with `bit_cnt < size` pulses `short_word` for one cycle and discards the whole frame (no `valid`).
  - The FSM continues with the next channel normally.
- **Output register:** a one-entry holding register.
  - A completed frame loads the holding register and sets `valid`.
  - `valid && ready` clears `valid`.
  - If a frame completes while `valid` = 1 and `ready` = 0: overwrite the register, keep `valid` = 1, and set `overrun`.
  - If a frame completes in the same cycle as acceptance: the new frame loads, `valid` stays 1, and `overrun` is not set.
- **Overrun clear:** `overrun` clears only on `rst`.

## Timing
- **Reset values:** `sample_left` = 0, `sample_right` = 0, `valid` = 0, `overrun` = 0, `short_word` = 0. FSM = HUNT, `bit_cnt` = 0, synchronizer flops = 0.
- **Reset mid-frame:** takes effect on the next `clk` edge. The partial frame is dropped and `valid` drops immediately.
- **Latency:** `valid` rises exactly 4 `clk` cycles after the pad-level SCK falling edge that samples the first left bit of the following frame:
  - 2 cycles synchronizer
  - 1 cycle edge detect
  - 1 cycle output register
- **Input timing:** SD and WS must be stable for at least 2 `clk` periods on either side of the SCK falling edge.
- **Outputs:** `valid`, data and `overrun` are registered. `ready` is combinationally sampled only.

## Structure
- **Package `i2s_pkg`:**
  - sample-size code constants (S_8BIT = 0, S_12BIT = 1, S_16BIT = 3, S_24BIT = 4, S_32BIT = 5)
  - the `size_decode` function (code → bit count)
  - channel constants LEFT = 0, RIGHT = 1
  - FSM state encoding
  
  The transmitter is migrated to the same package.
- **Sub-module `i2s_rx_sync`:** the three 2-flop synchronizers plus SCK falling-edge detection. Outputs `ws_s`, `sd_s` and `bit_strobe`.

## Test plan
- **Basic 16-bit frame:** `sample_size` = 3, LSB-first, one idle right channel then frame L = 0x1234, R = 0xABCD, `ready` = 1. Expect exactly one `valid` pulse with `sample_left` = 0x00001234 and `sample_right` = 0x0000ABCD.
- **Oversized channels with MSB_FIRST:** `MSB_FIRST` = 1, `sample_size` = 0, 32 SCK per channel, L = 0xA5, R = 0x3C. Expect `sample_left` = 0x000000A5 and `sample_right` = 0x0000003C; bits 9–32 of each channel are ignored.
- **Overrun:** `ready` = 0 across two 24-bit frames. Expect `overrun` = 1 and the holding register equal to the second frame. Then `ready` = 1: `valid` drops the next cycle and `overrun` stays 1.
- **Short word:** `sample_size` = 5 with WS toggling after 16 bits. Expect a `short_word` pulse per channel, no `valid`, and the next full 32-bit frame delivered correctly.
- **Reset and hunt:**
  - Assert `rst` mid-left-channel. Expect all outputs 0 the next cycle.
  - Release `rst` while WS = 0. Expect no capture until a WS 1→0 transition, then a correct frame.
- **Size change mid-frame:** change `sample_size` from 3 to 1 mid-right-channel. Expect the current frame completed as 16-bit and the next frame as 12-bit, with upper bits zero.
